nsum_seq_acc: RTL and testbench



---
 rtl/nsum_pkg.sv | 8 +
 rtl/nsum_term_gen.sv | 18 +
 rtl/nsum_seq_acc.sv | 64 ++++++
 tb/tb_nsum_seq_acc.sv | 112 +++++++++++
 4 files changed

// File: rtl/nsum_pkg.sv
// nsum_pkg: shared state/op encodings and result-width helper for the N-sum accumulator
package nsum_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {OP_SUM, OP_SQ, OP_ODD, OP_RSVD} op_e;
  function automatic int sum_w(input int n_w);
    return 3 * n_w;
  endfunction
endpackage

// File: rtl/nsum_term_gen.sv
// nsum_term_gen: combinational series term i, i*i or 2i-1; reserved op yields i
module nsum_term_gen
  import nsum_pkg::*;
#(
  parameter int N_W = 8
) (
  input  logic [N_W-1:0]   i,
  input  logic [1:0]       op,
  output logic [2*N_W-1:0] term
);
  logic [2*N_W-1:0] sq;
  logic [N_W:0] odd;
  always_comb begin
    sq = (2*N_W)'(i) * (2*N_W)'(i);
    odd = {i, 1'b0} - (N_W+1)'(1);
    term = op == OP_SQ ? sq : op == OP_ODD ? (2*N_W)'(odd) : (2*N_W)'(i);
  end
endmodule

// File: rtl/nsum_seq_acc.sv
// nsum_seq_acc: handshaked iterative series accumulator, one term per cycle from N down to 1.
// NSUM_PIPE_ACCEPT_EN lets DONE accept a new job in the cycle its result is consumed.
module nsum_seq_acc
  import nsum_pkg::*;
#(
  parameter int N_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_W-1:0]         n_in,
  input  logic [1:0]             op_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [sum_w(N_W)-1:0]  sum_out,
  output logic                   busy
);
  localparam int SUM_W = sum_w(N_W);
  state_e state, next;
  logic [N_W-1:0] i_q;
  logic [1:0] op_q;
  logic [SUM_W-1:0] acc;
  logic [2*N_W-1:0] term;
  logic accept;
  nsum_term_gen #(.N_W(N_W)) u_term (.i(i_q), .op(op_q), .term(term));
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = accept ? (n_in != '0 ? BUSY : DONE) : IDLE;
      BUSY: next = i_q == N_W'(1) ? DONE : BUSY;
      DONE: next = accept ? (n_in != '0 ? BUSY : DONE) : out_ready ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
`ifdef NSUM_PIPE_ACCEPT_EN
    in_ready = state == IDLE || (state == DONE && out_ready);
`else
    in_ready = state == IDLE;
`endif
    out_valid = state == DONE;
    busy = state == BUSY;
  end
  // Accumulator only moves on acceptance or in BUSY, so DONE holds it stable under backpressure
  always_ff @(posedge clk)
    if (reset) begin
      i_q <= '0;
      op_q <= OP_SUM;
      acc <= '0;
    end else if (accept) begin
      i_q <= n_in;
      op_q <= op_in;
      acc <= '0;
    end else if (state == BUSY) begin
      acc <= acc + SUM_W'(term);
      i_q <= i_q - N_W'(1);
    end
  assign sum_out = acc;
endmodule

// File: tb/tb_nsum_seq_acc.sv
// tb_nsum_seq_acc: directed-vector self-checking bench for nsum_seq_acc (N_W = 8)
module tb_nsum_seq_acc;
  logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] n_in = 0;
  logic [1:0] op_in = 0;
  logic [23:0] sum_out;
  int total = 0, bad = 0;
  nsum_seq_acc #(.N_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .n_in(n_in), .op_in(op_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_job(input string tag, input logic [7:0] n, input logic [1:0] op,
                         input logic [23:0] exp_sum, input int exp_edges, input bit exp_busy);
    int edges = 0;
    bit seen = 0;
    @(negedge clk);
    in_valid = 1; n_in = n; op_in = op;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      in_valid = 0;
      if (busy) seen = 1;
    end while (!out_valid && edges < 600);
    chk({tag, "_edges"}, edges, exp_edges);
    chk({tag, "_sum"}, sum_out, exp_sum);
    chk({tag, "_busy_seen"}, seen, exp_busy);
  endtask
  task automatic ack(input string tag);
    out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 0;
    chk({tag, "_ack_valid"}, out_valid, 0);
    chk({tag, "_ack_ready"}, in_ready, 1);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum_out, 0);
    run_job("n5_sum", 5, 2'b00, 15, 6, 1); ack("n5_sum");
    run_job("n3_sq", 3, 2'b01, 14, 4, 1); ack("n3_sq");
    run_job("n4_odd", 4, 2'b10, 16, 5, 1); ack("n4_odd");
    run_job("n4_rsvd", 4, 2'b11, 10, 5, 1); ack("n4_rsvd");
    run_job("n0_sq", 0, 2'b01, 0, 1, 0); ack("n0_sq");
    run_job("n255_sq", 255, 2'b01, 5559680, 256, 1); ack("n255_sq");
    run_job("n255_sum", 255, 2'b00, 32640, 256, 1); ack("n255_sum");
    run_job("n1_odd", 1, 2'b10, 1, 2, 1); ack("n1_odd");
    run_job("stall", 6, 2'b00, 21, 7, 1);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; n_in = 3; op_in = 2'b01;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      chk("stall_valid", out_valid, 1);
      chk("stall_sum", sum_out, 21);
      chk("stall_busy", busy, 0);
    end
    in_valid = 1; n_in = 3; op_in = 2'b00; out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0; out_ready = 0;
`ifdef NSUM_PIPE_ACCEPT_EN
    chk("pipe_busy", busy, 1);
    chk("pipe_valid", out_valid, 0);
    begin
      int e = 0;
      while (!out_valid && e < 20) begin @(posedge clk); e++; @(negedge clk); end
      chk("pipe_edges", e, 3);
      chk("pipe_sum", sum_out, 6);
    end
    ack("pipe");
`else
    chk("nopipe_busy", busy, 0);
    chk("nopipe_ready", in_ready, 1);
    chk("nopipe_valid", out_valid, 0);
`endif
    @(negedge clk);
    in_valid = 1; n_in = 7; op_in = 2'b00;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum_out, 0);
    run_job("post_rst", 2, 2'b00, 3, 3, 1); ack("post_rst");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
